// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: compacting push, show-ahead pop, flush, sticky overflow.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency path when the queue is empty.
package core_pkg;
   localparam int unsigned ISSUE__WIDTH = 2;
   localparam int unsigned XLEN         = 32;
endpackage

module fetch_queue #(
   parameter int unsigned FETCH_W = core_pkg::ISSUE__WIDTH,
   parameter int unsigned PC_W    = core_pkg::XLEN,
   parameter int unsigned INSTR_W = core_pkg::XLEN,
   parameter int unsigned DEPTH   = 8
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic [FETCH_W-1:0]                i_if_valid,
   input  logic [FETCH_W-1:0][PC_W-1:0]      i_if_pc,
   input  logic [FETCH_W-1:0][INSTR_W-1:0]   i_if_instr,
   output logic                              o_fetch_stall,
   input  logic                              i_flush,
   output logic [FETCH_W-1:0]                o_dec_valid,
   output logic [FETCH_W-1:0][PC_W-1:0]      o_dec_pc,
   output logic [FETCH_W-1:0][INSTR_W-1:0]   o_dec_instr,
   input  logic                              i_dec_ready,
   output logic [$clog2(DEPTH):0]            o_count,
   output logic                              o_overflow_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow;
   logic [PC_W-1:0]    r_mem_pc    [DEPTH];
   logic [INSTR_W-1:0] r_mem_instr [DEPTH];

   logic [FETCH_W-1:0][CNT_W-1:0] w_off;
   logic [CNT_W-1:0]              w_acc;
   logic [CNT_W-1:0]              w_npop;
   logic [CNT_W-1:0]              w_free;
   logic [CNT_W-1:0]              w_nwr;
   logic [FETCH_W-1:0]            w_wr_en;
   logic [FETCH_W-1:0][PTR_W-1:0] w_wr_addr;
   logic                          w_drop;
   logic                          w_byp_take;
   logic                          w_pop_en;

   // Rank of each valid fetch slot among the valid slots below it (compaction offset).
   always_comb begin
      w_acc = '0;
      w_off = '0;
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         w_off[i] = w_acc;
         if (i_if_valid[i]) w_acc = w_acc + CNT_W'(1);
      end
   end

`ifdef FETCH_QUEUE_BYPASS_EN
   logic                             w_bypass;
   logic [FETCH_W-1:0]               w_byp_valid;
   logic [FETCH_W-1:0][PC_W-1:0]     w_byp_pc;
   logic [FETCH_W-1:0][INSTR_W-1:0]  w_byp_instr;

   assign w_bypass   = (r_count == '0) && !i_flush;
   assign w_byp_take = w_bypass && i_dec_ready;
   assign w_pop_en   = i_dec_ready && !w_bypass;

   always_comb begin
      w_byp_valid = '0;
      w_byp_pc    = '0;
      w_byp_instr = '0;
      for (int unsigned j = 0; j < FETCH_W; j++) begin
         for (int unsigned i = 0; i < FETCH_W; i++) begin
            if (i_if_valid[i] && (w_off[i] == CNT_W'(j))) begin
               w_byp_valid[j] = 1'b1;
               w_byp_pc[j]    = i_if_pc[i];
               w_byp_instr[j] = i_if_instr[i];
            end
         end
      end
   end
`else
   assign w_byp_take = 1'b0;
   assign w_pop_en   = i_dec_ready;
`endif

   always_comb begin
      o_dec_valid = '0;
      o_dec_pc    = '0;
      o_dec_instr = '0;
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         o_dec_valid[i] = (r_count > CNT_W'(i)) && !i_flush;
         o_dec_pc[i]    = r_mem_pc[r_rd_ptr + PTR_W'(i)];
         o_dec_instr[i] = r_mem_instr[r_rd_ptr + PTR_W'(i)];
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      if (w_bypass) begin
         o_dec_valid = w_byp_valid;
         o_dec_pc    = w_byp_pc;
         o_dec_instr = w_byp_instr;
      end
`endif
   end

   // Free space counts entries popped this cycle, so a full queue can accept a push while draining.
   always_comb begin
      w_npop    = '0;
      w_nwr     = '0;
      w_drop    = 1'b0;
      w_wr_en   = '0;
      w_wr_addr = '0;
      if (w_pop_en) begin
         for (int unsigned i = 0; i < FETCH_W; i++) begin
            w_npop = w_npop + CNT_W'(o_dec_valid[i]);
         end
      end
      w_free = CNT_W'(DEPTH) - r_count + w_npop;
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         w_wr_addr[i] = r_wr_ptr + w_off[i][PTR_W-1:0];
         if (i_if_valid[i] && !i_flush && !w_byp_take) begin
            if (w_off[i] < w_free) begin
               w_wr_en[i] = 1'b1;
               w_nwr      = w_nwr + CNT_W'(1);
            end else begin
               w_drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + w_nwr[PTR_W-1:0];
         r_rd_ptr <= r_rd_ptr + w_npop[PTR_W-1:0];
         r_count  <= r_count + w_nwr - w_npop;
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         if (w_wr_en[i]) begin
            r_mem_pc[w_wr_addr[i]]    <= i_if_pc[i];
            r_mem_instr[w_wr_addr[i]] <= i_if_instr[i];
         end
      end
   end

   assign o_fetch_stall  = (CNT_W'(DEPTH) - r_count) < CNT_W'(2 * FETCH_W);
   assign o_count        = r_count;
   assign o_overflow_err = r_overflow;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build) with a queue-based reference model.
module tb_fetch_queue;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        if_valid;
   logic [1:0][31:0]  if_pc;
   logic [1:0][31:0]  if_instr;
   logic              fetch_stall;
   logic              flush;
   logic [1:0]        dec_valid;
   logic [1:0][31:0]  dec_pc;
   logic [1:0][31:0]  dec_instr;
   logic              dec_ready;
   logic [3:0]        count;
   logic              overflow_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] mq_pc [$];
   logic [31:0] mq_in [$];
   logic        m_ovf = 1'b0;

   fetch_queue #(.FETCH_W(2), .PC_W(32), .INSTR_W(32), .DEPTH(8)) dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_if_valid(if_valid), .i_if_pc(if_pc), .i_if_instr(if_instr),
      .o_fetch_stall(fetch_stall), .i_flush(flush),
      .o_dec_valid(dec_valid), .o_dec_pc(dec_pc), .o_dec_instr(dec_instr),
      .i_dec_ready(dec_ready), .o_count(count), .o_overflow_err(overflow_err)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                        input logic rdy, input logic fl);
      if_valid    = v;
      if_pc[0]    = p0;
      if_pc[1]    = p1;
      if_instr[0] = p0 ^ 32'h1337_0013;
      if_instr[1] = p1 ^ 32'h1337_0013;
      dec_ready   = rdy;
      flush       = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   // Reference model: an ordered list of entries, consumed from the front and appended at the back.
   always @(posedge clk) begin : model
      int np;
      int free;
      if (rst_n) begin
         if (flush) begin
            mq_pc.delete();
            mq_in.delete();
         end else begin
            np = 0;
            if (dec_ready) np = (mq_pc.size() >= 2) ? 2 : mq_pc.size();
            repeat (np) begin
               void'(mq_pc.pop_front());
               void'(mq_in.pop_front());
            end
            free = 8 - mq_pc.size();
            for (int i = 0; i < 2; i++) begin
               if (if_valid[i]) begin
                  if (free > 0) begin
                     mq_pc.push_back(if_pc[i]);
                     mq_in.push_back(if_instr[i]);
                     free--;
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
            end
         end
      end
   end

   always @(negedge rst_n) begin
      mq_pc.delete();
      mq_in.delete();
      m_ovf = 1'b0;
   end

   always @(negedge clk) begin : compare
      logic ev;
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            ev = (mq_pc.size() > i) && !flush;
            chk($sformatf("m_valid%0d", i), 32'(dec_valid[i]), 32'(ev));
            if (ev) begin
               chk($sformatf("m_pc%0d", i), dec_pc[i], mq_pc[i]);
               chk($sformatf("m_instr%0d", i), dec_instr[i], mq_in[i]);
            end
         end
         chk("m_count", 32'(count), 32'(mq_pc.size()));
         chk("m_stall", 32'(fetch_stall), 32'((8 - mq_pc.size()) < 4));
         chk("m_ovf", 32'(overflow_err), 32'(m_ovf));
      end
   end

   initial begin
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      #12;
      chk("rst_count", 32'(count), 0);
      chk("rst_valid", 32'(dec_valid), 0);
      chk("rst_stall", 32'(fetch_stall), 0);
      chk("rst_ovf", 32'(overflow_err), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic push, then flush back to empty
      apply(2'b11, 32'h00, 32'h04, 1'b0, 1'b0); tick();
      chk("t1_count", 32'(count), 2);
      chk("t1_valid", 32'(dec_valid), 32'h3);
      chk("t1_pc0", dec_pc[0], 32'h00);
      chk("t1_pc1", dec_pc[1], 32'h04);
      chk("t1_instr0", dec_instr[0], 32'h1337_0013);
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1); tick();
      chk("t1_flushed", 32'(count), 0);

      // Only slot 1 valid: compacted into entry 0
      apply(2'b10, 32'hDEAD_0000, 32'h14, 1'b0, 1'b0); tick();
      chk("t4_count", 32'(count), 1);
      chk("t4_pc0", dec_pc[0], 32'h14);
      chk("t4_valid", 32'(dec_valid), 32'h1);
      apply(2'b00, 32'h0, 32'h0, 1'b1, 1'b0); tick();
      chk("t4_drained", 32'(count), 0);

      // Fill from empty (pointers start at 1, so the fourth bundle wraps 7->0)
      for (int k = 0; k < 3; k++) begin
         apply(2'b11, 32'h100 + 8 * k, 32'h104 + 8 * k, 1'b0, 1'b0); tick();
      end
      chk("t2_count6", 32'(count), 6);
      chk("t2_stall", 32'(fetch_stall), 1);
      apply(2'b11, 32'h118, 32'h11C, 1'b0, 1'b0); tick();
      chk("t2_count8", 32'(count), 8);
      chk("t2_no_ovf", 32'(overflow_err), 0);

      // Full with simultaneous pop and push
      apply(2'b11, 32'h120, 32'h124, 1'b1, 1'b0); tick();
      chk("t3_count", 32'(count), 8);
      chk("t3_pc0", dec_pc[0], 32'h108);
      chk("t3_pc1", dec_pc[1], 32'h10C);
      chk("t3_no_ovf", 32'(overflow_err), 0);
      repeat (2) begin apply(2'b00, 32'h0, 32'h0, 1'b1, 1'b0); tick(); end
      chk("t3_wrap_pc0", dec_pc[0], 32'h118);
      chk("t3_wrap_pc1", dec_pc[1], 32'h11C);
      chk("t3_count4", 32'(count), 4);
      repeat (2) begin apply(2'b00, 32'h0, 32'h0, 1'b1, 1'b0); tick(); end
      chk("t3_empty", 32'(count), 0);
      chk("t3_empty_valid", 32'(dec_valid), 0);

      // Flush with a concurrent push at count=5
      apply(2'b11, 32'h200, 32'h204, 1'b0, 1'b0); tick();
      apply(2'b11, 32'h208, 32'h20C, 1'b0, 1'b0); tick();
      apply(2'b01, 32'h210, 32'h0, 1'b0, 1'b0); tick();
      chk("t5_count5", 32'(count), 5);
      apply(2'b11, 32'h08, 32'h0C, 1'b0, 1'b1);
      #1;
      chk("t5_flush_valid", 32'(dec_valid), 0);
      tick();
      chk("t5_count0", 32'(count), 0);
      chk("t5_valid0", 32'(dec_valid), 0);
      apply(2'b11, 32'h08, 32'h0C, 1'b0, 1'b0); tick();
      chk("t5_pc0", dec_pc[0], 32'h08);
      chk("t5_count2", 32'(count), 2);

      // Overflow: push 2 at count=7 without pop
      apply(2'b11, 32'h300, 32'h304, 1'b0, 1'b0); tick();
      apply(2'b11, 32'h308, 32'h30C, 1'b0, 1'b0); tick();
      apply(2'b01, 32'h310, 32'h0, 1'b0, 1'b0); tick();
      chk("t6_count7", 32'(count), 7);
      chk("t6_pre_ovf", 32'(overflow_err), 0);
      apply(2'b11, 32'h318, 32'h31C, 1'b0, 1'b0); tick();
      chk("t6_count8", 32'(count), 8);
      chk("t6_ovf", 32'(overflow_err), 1);
      repeat (2) tick();
      chk("t6_ovf_held", 32'(overflow_err), 1);
      chk("t6_count_held", 32'(count), 8);

      // Asynchronous reset in mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_count", 32'(count), 0);
      chk("t6_rst_valid", 32'(dec_valid), 0);
      chk("t6_rst_stall", 32'(fetch_stall), 0);
      chk("t6_rst_ovf", 32'(overflow_err), 0);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      apply(2'b11, 32'h400, 32'h404, 1'b0, 1'b0); tick();
      chk("post_count", 32'(count), 2);
      chk("post_pc0", dec_pc[0], 32'h400);
      chk("post_pc1", dec_pc[1], 32'h404);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
